zigzag_reorder: RTL and testbench
=================================

ZIGZAG_REORDER -- requirements
Module: zigzag_reorder

Interface
REQ-001 Parameter DATA_W, default 12, coefficient width in bits (signed two's complement).
REQ-002 sys_clk  input  1  rising-edge clock for all state.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 din_valid  input  1  din carries a coefficient this cycle.
REQ-005 din  input  DATA_W  signed DCT coefficient, row-major order within an 8x8 block.
REQ-006 dout  output  DATA_W  signed coefficient in zigzag order.
REQ-007 dout_valid  output  1  dout valid this cycle.
REQ-008 dout_sob  output  1  high with zigzag index 0 of each block.
REQ-009 dout_eob  output  1  high with zigzag index 63 of each block.
REQ-010 ovf_err  output  1  sticky overflow flag (see Configuration).

Function
REQ-011 Storage SHALL be two 64 x DATA_W banks (ping-pong); write and read always target different banks.
REQ-012 Write side: each din_valid cycle SHALL store din at row-major address wr_cnt (0..63) of the write bank, then increment wr_cnt.
REQ-013 Gaps in din_valid SHALL hold wr_cnt and the write bank; no data lost or duplicated.
REQ-014 On the write at wr_cnt=63: wr_cnt wraps to 0, the bank is marked full, and the write bank toggles on the same edge.
REQ-015 Read FSM states: IDLE, READ; IDLE->READ when a full bank exists; READ->IDLE after zigzag index 63 unless the other bank is already full, in which case READ continues into it with no idle cycle.
REQ-016 READ SHALL issue one address per cycle: rd_cnt 0..63 through a fixed 64-entry zigzag LUT (0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,...,55,62,63).
REQ-017 Latency: the first dout_valid SHALL occur exactly 2 cycles after the edge capturing the block's 64th coefficient (LUT/memory read register, then output register).
REQ-018 Output SHALL be 64 consecutive dout_valid cycles per block, no bubbles; no downstream backpressure.
REQ-019 The bank's full mark SHALL clear on the edge issuing rd_cnt=63.
REQ-020 Values SHALL pass unmodified; sign preserved, no saturation or truncation.
REQ-021 When dout_valid is low, dout SHALL hold its last value; dout_sob/dout_eob SHALL be low.
REQ-022 Simultaneous last write to bank A and last read of bank B SHALL be legal: A becomes readable, B becomes writable, same edge.

Reset
REQ-023 On sys_rst_n low: wr_cnt=0, rd_cnt=0, write bank=0, both full marks cleared, FSM=IDLE.
REQ-024 Outputs reset: dout=0, dout_valid=0, dout_sob=0, dout_eob=0, ovf_err=0.
REQ-025 Memory contents need not reset; a partially written or partially read block at reset SHALL be discarded with no output after release.

Configuration
REQ-026 Macro ZZ_OVF_DETECT_EN.
REQ-027 Defined: ovf_err SHALL set (sticky until reset) when din_valid arrives while the write bank is still marked full; that coefficient is dropped and wr_cnt held.
REQ-028 Undefined: ovf_err SHALL be tied 0; such a write overwrites the bank (undefined output data), and no detection logic is synthesised.

Verification
REQ-029 Ramp: din=0..63 continuous -> dout=0,1,8,16,9,2,3,10,...,62,63; sob on the first output, eob on the 64th; first output 2 cycles after last input.
REQ-030 Back-to-back: 3 blocks (ramps with offsets 0, 100, 200) continuous -> 192 contiguous dout_valid cycles, each block correctly zigzagged.
REQ-031 Gapped input: din_valid toggling 1-0 for one block -> identical output sequence as the ramp; read starts 2 cycles after the 64th valid.
REQ-032 Signed: block with din=-2048 at index 63 and +2047 at index 0 -> dout=+2047 at sob, -2048 at eob.
REQ-033 Reset mid-block: assert sys_rst_n after 30 inputs, then feed a full ramp -> only the ramp block appears, all outputs 0 during reset.
REQ-034 Overflow (ZZ_OVF_DETECT_EN): force both banks full, then din_valid=1 -> ovf_err rises next edge and stays 1; without the macro ovf_err remains 0.

Source files
------------

// File: rtl/zigzag_reorder_if.sv
// Coefficient stream bundle for zigzag_reorder: row-major input side and zigzag output side.
// master drives din/din_valid and observes outputs; slave is the reorder block.
interface zigzag_reorder_if #(
  parameter int DATA_W = 12
);
  logic                     din_valid;
  logic signed [DATA_W-1:0] din;
  logic signed [DATA_W-1:0] dout;
  logic                     dout_valid;
  logic                     dout_sob;
  logic                     dout_eob;
  logic                     ovf_err;

  modport master (
    output din_valid, din,
    input  dout, dout_valid, dout_sob, dout_eob, ovf_err
  );

  modport slave (
    input  din_valid, din,
    output dout, dout_valid, dout_sob, dout_eob, ovf_err
  );
endinterface

// File: rtl/zigzag_reorder.sv
// 8x8 block zigzag reorder with ping-pong banks: row-major in, zigzag out, 2-cycle read latency.
// Optional write-overflow detection is enabled by defining ZZ_OVF_DETECT_EN.
module zigzag_reorder #(
  parameter int DATA_W = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  zigzag_reorder_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_e;

  // Zigzag index -> row-major address within the 8x8 block.
  localparam logic [5:0] ZZ_LUT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic signed [DATA_W-1:0] mem_q [128];

  state_e                   state_q, state_d;
  logic [5:0]               wr_cnt_q, wr_cnt_d;
  logic [5:0]               rd_cnt_q, rd_cnt_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [1:0]               full_q, full_d;
  logic                     rd_vld_q, rd_vld_d;
  logic                     rd_sob_q, rd_sob_d;
  logic                     rd_eob_q, rd_eob_d;
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic                     dout_sob_q, dout_sob_d;
  logic                     dout_eob_q, dout_eob_d;

  logic                     wr_en;
  logic                     rd_issue;
  logic                     rd_last;

`ifdef ZZ_OVF_DETECT_EN
  logic ovf_q, ovf_d;

  // A write into a bank still awaiting readout is dropped and flagged.
  assign wr_en = bus.din_valid && !full_q[wr_bank_q];

  always_comb begin
    ovf_d = ovf_q | (bus.din_valid & full_q[wr_bank_q]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  assign bus.ovf_err = ovf_q;
`else
  assign wr_en       = bus.din_valid;
  assign bus.ovf_err = 1'b0;
`endif

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) wr_bank_d = ~wr_bank_q;
    end
  end

  // Clear before set so a bank finishing read and one finishing write can share an edge.
  always_comb begin
    full_d = full_q;
    if (rd_issue && rd_last)             full_d[rd_bank_q] = 1'b0;
    if (wr_en && (wr_cnt_q == 6'd63))    full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (full_q[rd_bank_q]) state_d = READ;
      READ: if (rd_last && !full_q[~rd_bank_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IDLE issues zigzag index 0 in the same cycle a full bank is seen, saving a cycle of latency.
  always_comb begin
    rd_last   = (rd_cnt_q == 6'd63);
    rd_issue  = (state_q == READ) || full_q[rd_bank_q];
    rd_cnt_d  = rd_issue ? rd_cnt_q + 6'd1 : rd_cnt_q;
    rd_bank_d = (rd_issue && rd_last) ? ~rd_bank_q : rd_bank_q;
    rd_vld_d  = rd_issue;
    rd_sob_d  = rd_issue && (rd_cnt_q == 6'd0);
    rd_eob_d  = rd_issue && rd_last;
    rd_data_d = mem_q[{rd_bank_q, ZZ_LUT[rd_cnt_q]}];
  end

  always_comb begin
    dout_d       = rd_vld_q ? rd_data_q : dout_q;
    dout_valid_d = rd_vld_q;
    dout_sob_d   = rd_vld_q & rd_sob_q;
    dout_eob_d   = rd_vld_q & rd_eob_q;
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_cnt_q}] <= bus.din;
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      wr_cnt_q     <= 6'd0;
      rd_cnt_q     <= 6'd0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= 2'b00;
      rd_vld_q     <= 1'b0;
      rd_sob_q     <= 1'b0;
      rd_eob_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sob_q   <= 1'b0;
      dout_eob_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      rd_vld_q     <= rd_vld_d;
      rd_sob_q     <= rd_sob_d;
      rd_eob_q     <= rd_eob_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sob_q   <= dout_sob_d;
      dout_eob_q   <= dout_eob_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_sob   = dout_sob_q;
  assign bus.dout_eob   = dout_eob_q;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Scoreboard bench for zigzag_reorder: a diagonal-walk model predicts data, flags and output cycle.
// Define ZZ_OVF_DETECT_EN to also exercise the overflow flag.
module tb_zigzag_reorder;

  localparam int DATA_W = 12;

  typedef struct {
    int data;
    bit sob;
    bit eob;
    int cyc;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  zigzag_reorder_if #(.DATA_W(DATA_W)) bus ();

  zigzag_reorder #(.DATA_W(DATA_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  exp_t exp_q[$];
  exp_t mon_e;
  int   zz_order [64];
  int   blk      [64];
  int   blk_n    = 0;
  int   cyc      = 0;
  int   last_end = 0;
  int   last_exp = 0;
  bit   ovf_exp  = 1'b0;
  bit   chk_en   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Zigzag order walks anti-diagonals r+c=s, alternating direction.
  function automatic void buildOrder();
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_order[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_order[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic void modelCapture(input int value);
    blk[blk_n] = value;
    blk_n++;
    if (blk_n == 64) begin
      int start = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
      for (int k = 0; k < 64; k++) begin
        exp_t e;
        e.data = blk[zz_order[k]];
        e.sob  = (k == 0);
        e.eob  = (k == 63);
        e.cyc  = start + k;
        exp_q.push_back(e);
      end
      last_end = start + 63;
      blk_n    = 0;
    end
  endfunction

  task automatic applyStimulus(input int value, input bit valid);
    bus.din_valid = valid;
    bus.din       = DATA_W'(value);
    @(posedge sys_clk);
    #1;
    if (valid) modelCapture(value);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1'b0);
  endtask

  task automatic applyReset();
    sys_rst_n = 1'b0;
    exp_q.delete();
    blk_n    = 0;
    last_end = 0;
    last_exp = 0;
    ovf_exp  = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("rst_dout",       int'(bus.dout),       0);
    checkOutput("rst_dout_valid", int'(bus.dout_valid), 0);
    checkOutput("rst_sob",        int'(bus.dout_sob),   0);
    checkOutput("rst_eob",        int'(bus.dout_eob),   0);
    checkOutput("rst_ovf",        int'(bus.ovf_err),    0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge sys_clk);
      n++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
    idle(4);
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("dout",     int'(bus.dout),     mon_e.data);
          checkOutput("sob",      int'(bus.dout_sob), int'(mon_e.sob));
          checkOutput("eob",      int'(bus.dout_eob), int'(mon_e.eob));
          checkOutput("out_cyc",  cyc,                mon_e.cyc);
          last_exp = mon_e.data;
        end
      end else begin
        checkOutput("idle_sob",  int'(bus.dout_sob), 0);
        checkOutput("idle_eob",  int'(bus.dout_eob), 0);
        checkOutput("hold_dout", int'(bus.dout),     last_exp);
      end
      checkOutput("ovf_err", int'(bus.ovf_err), int'(ovf_exp));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    buildOrder();
    chk_en = 1'b1;
    applyReset();

    $display("[TB] ramp");
    for (int i = 0; i < 64; i++) applyStimulus(i, 1'b1);
    bus.din_valid = 1'b0;
    drain();

    $display("[TB] back-to-back three blocks");
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 64; i++) applyStimulus(b * 100 + i, 1'b1);
    bus.din_valid = 1'b0;
    drain();

    $display("[TB] gapped ramp");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(i, 1'b1);
      applyStimulus(0, 1'b0);
    end
    drain();

    $display("[TB] signed extremes");
    for (int i = 0; i < 64; i++) begin
      if (i == 0)       v = 2047;
      else if (i == 63) v = -2048;
      else              v = int'($urandom_range(0, 4095)) - 2048;
      applyStimulus(v, 1'b1);
    end
    bus.din_valid = 1'b0;
    drain();

    $display("[TB] reset mid-block");
    for (int i = 0; i < 30; i++) applyStimulus(500 + i, 1'b1);
    applyReset();
    for (int i = 0; i < 64; i++) applyStimulus(i, 1'b1);
    bus.din_valid = 1'b0;
    drain();

    $display("[TB] random blocks with random gaps");
    for (int b = 0; b < 5; b++) begin
      int sent = 0;
      while (sent < 64) begin
        if ($urandom_range(0, 3) != 0) begin
          applyStimulus(int'($urandom_range(0, 4095)) - 2048, 1'b1);
          sent++;
        end else begin
          applyStimulus(0, 1'b0);
        end
      end
      if (b % 2 == 1) idle(int'($urandom_range(0, 80)));
    end
    bus.din_valid = 1'b0;
    drain();

`ifdef ZZ_OVF_DETECT_EN
    $display("[TB] overflow flag");
    chk_en = 1'b0;
    force dut.full_q = 2'b11;
    @(negedge sys_clk);
    checkOutput("ovf_pre", int'(bus.ovf_err), 0);
    bus.din_valid = 1'b1;
    bus.din       = DATA_W'(5);
    @(posedge sys_clk);
    #1;
    bus.din_valid = 1'b0;
    checkOutput("ovf_rise", int'(bus.ovf_err), 1);
    release dut.full_q;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("ovf_sticky", int'(bus.ovf_err), 1);
    applyReset();
    chk_en = 1'b1;
    idle(4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
